// File: rtl/buffet_read_arbiter_if.sv
// Request/response/buffet bundle for buffet_read_arbiter.
// slave = arbiter side, master = consumers plus buffet (environment) side.
interface buffet_read_arbiter_if #(
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
);
  logic [IDX_WIDTH-1:0]  req0_idx, req1_idx;
  logic                  req0_will_update, req0_is_shrink, req0_valid, req0_ready;
  logic                  req1_will_update, req1_is_shrink, req1_valid, req1_ready;
  logic [DATA_WIDTH-1:0] rsp0_data, rsp1_data;
  logic                  rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [IDX_WIDTH-1:0]  read_idx;
  logic                  read_will_update, is_shrink, read_idx_valid, read_idx_ready;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_data_valid, read_data_ready;

  modport slave (
    input  req0_idx, req0_will_update, req0_is_shrink, req0_valid,
    input  req1_idx, req1_will_update, req1_is_shrink, req1_valid,
    output req0_ready, req1_ready,
    output rsp0_data, rsp0_valid, rsp1_data, rsp1_valid,
    input  rsp0_ready, rsp1_ready,
    output read_idx, read_will_update, is_shrink, read_idx_valid,
    input  read_idx_ready,
    input  read_data, read_data_valid,
    output read_data_ready
  );

  modport master (
    output req0_idx, req0_will_update, req0_is_shrink, req0_valid,
    output req1_idx, req1_will_update, req1_is_shrink, req1_valid,
    input  req0_ready, req1_ready,
    input  rsp0_data, rsp0_valid, rsp1_data, rsp1_valid,
    output rsp0_ready, rsp1_ready,
    input  read_idx, read_will_update, is_shrink, read_idx_valid,
    output read_idx_ready,
    output read_data, read_data_valid,
    input  read_data_ready
  );
endinterface

// File: rtl/buffet_read_arbiter.sv
// Two-consumer round-robin arbiter for one buffet read/shrink port; a tag FIFO steers in-order read data back.
// Optional BUFFET_RDARB_PERF_EN adds per-requester grant counters and a stall-cycle counter.
module buffet_read_arbiter #(
  parameter int IDX_WIDTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  nreset_i,
  buffet_read_arbiter_if.slave  bus,
`ifdef BUFFET_RDARB_PERF_EN
  output logic [15:0]           gnt0_cnt,
  output logic [15:0]           gnt1_cnt,
  output logic [15:0]           stall_cnt,
`endif
  output logic                  err_o
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  logic [1:0]                req_v, req_sh, req_wu, elig, gnt, rsp_rdy;
  logic [1:0][IDX_WIDTH-1:0] req_idx;
  logic                      winner, load, push, pop, head, has_tag, not_full;
  logic [DATA_WIDTH-1:0]     rd_data;

  logic                      prio_q, out_valid_q, wu_q, sh_q, err_q;
  logic [IDX_WIDTH-1:0]      idx_q;
  logic [TAG_DEPTH-1:0]      tag_q;
  logic [PW-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             tag_cnt_q;

  assign req_v   = {bus.req1_valid,       bus.req0_valid};
  assign req_sh  = {bus.req1_is_shrink,   bus.req0_is_shrink};
  assign req_wu  = {bus.req1_will_update, bus.req0_will_update};
  assign req_idx = {bus.req1_idx,         bus.req0_idx};
  assign rsp_rdy = {bus.rsp1_ready,       bus.rsp0_ready};

  // Eligibility uses the registered count only; a same-cycle pop never frees a slot early.
  assign has_tag  = (tag_cnt_q != '0);
  assign not_full = (tag_cnt_q < CW'(TAG_DEPTH));
  assign elig     = req_v & (req_sh | {2{not_full}});

  assign gnt[0] = elig[0] & (~elig[1] | ~prio_q);
  assign gnt[1] = elig[1] & (~elig[0] |  prio_q);
  assign winner = gnt[1];
  assign load   = (|gnt) & (~out_valid_q | bus.read_idx_ready);
  assign push   = load & ~req_sh[winner];

  assign bus.req0_ready       = gnt[0] & load;
  assign bus.req1_ready       = gnt[1] & load;
  assign bus.read_idx         = idx_q;
  assign bus.read_will_update = wu_q;
  assign bus.is_shrink        = sh_q;
  assign bus.read_idx_valid   = out_valid_q;

  // Buffet answers in issue order, so the FIFO head names the owner of the current data beat.
  assign head                = tag_q[rd_ptr_q];
  assign rd_data             = bus.read_data;
  assign bus.rsp0_data       = rd_data;
  assign bus.rsp1_data       = rd_data;
  assign bus.rsp0_valid      = bus.read_data_valid & has_tag & ~head;
  assign bus.rsp1_valid      = bus.read_data_valid & has_tag &  head;
  assign bus.read_data_ready = has_tag & rsp_rdy[head];
  assign pop                 = bus.read_data_valid & bus.read_data_ready;
  assign err_o               = err_q;

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      wu_q        <= 1'b0;
      sh_q        <= 1'b0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if (|gnt) prio_q <= ~winner;
      if (load) begin
        out_valid_q <= 1'b1;
        idx_q       <= req_idx[winner];
        wu_q        <= req_wu[winner];
        sh_q        <= req_sh[winner];
      end else if (bus.read_idx_ready) begin
        out_valid_q <= 1'b0;
      end
      if (push) begin
        tag_q[wr_ptr_q] <= winner;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   tag_cnt_q <= tag_cnt_q + CW'(1);
        2'b01:   tag_cnt_q <= tag_cnt_q - CW'(1);
        default: ;
      endcase
      // Stray data with nothing outstanding is dropped (ready stays low) and flagged for good.
      if (bus.read_data_valid && !has_tag) err_q <= 1'b1;
    end
  end

`ifdef BUFFET_RDARB_PERF_EN
  logic [15:0] gnt0_q, gnt1_q, stall_q;

  always_ff @(posedge clk or negedge nreset_i) begin
    if (!nreset_i) begin
      gnt0_q  <= '0;
      gnt1_q  <= '0;
      stall_q <= '0;
    end else begin
      if (load && gnt[0] && !(&gnt0_q)) gnt0_q <= gnt0_q + 16'd1;
      if (load && gnt[1] && !(&gnt1_q)) gnt1_q <= gnt1_q + 16'd1;
      if ((|req_v) && !load && !(&stall_q)) stall_q <= stall_q + 16'd1;
    end
  end

  assign gnt0_cnt  = gnt0_q;
  assign gnt1_cnt  = gnt1_q;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_buffet_read_arbiter.sv
// Scoreboard bench for buffet_read_arbiter: expected read_idx beats and per-requester responses are
// queued at stimulus time and retired by a negedge monitor; scenario tasks add inline checks.
module tb_buffet_read_arbiter;
  logic clk = 1'b0;
  logic nreset_i;
  logic err_o;
`ifdef BUFFET_RDARB_PERF_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  buffet_read_arbiter_if #(.IDX_WIDTH(8), .DATA_WIDTH(32)) bus ();

  buffet_read_arbiter #(.IDX_WIDTH(8), .DATA_WIDTH(32), .TAG_DEPTH(4)) dut (
    .clk      (clk),
    .nreset_i (nreset_i),
    .bus      (bus),
`ifdef BUFFET_RDARB_PERF_EN
    .gnt0_cnt (gnt0_cnt),
    .gnt1_cnt (gnt1_cnt),
    .stall_cnt(stall_cnt),
`endif
    .err_o    (err_o)
  );

  typedef struct packed {logic [7:0] idx; logic wu; logic sh;} rd_t;

  int          total = 0;
  int          bad   = 0;
  rd_t         exp_rd[$];
  logic [31:0] exp_rsp0[$], exp_rsp1[$], buf_q[$];
  bit          buf_auto = 0;
  rd_t         mon_got, mon_exp;
  logic [31:0] mon_d;

  function automatic logic [31:0] dat(input logic [7:0] i);
    return 32'hDA7A_0000 | {24'h0, i};
  endfunction

  function automatic rd_t mk(input logic [7:0] i, input logic wu, input logic sh);
    rd_t r;
    r.idx = i; r.wu = wu; r.sh = sh;
    return r;
  endfunction

  // Scoreboard monitor plus in-order buffet model (active when buf_auto is set).
  always @(negedge clk) begin
    if (nreset_i) begin
      if (bus.read_idx_valid && bus.read_idx_ready) begin
        mon_got = mk(bus.read_idx, bus.read_will_update, bus.is_shrink);
        total++;
        if (exp_rd.size() == 0) begin
          bad++; $display("FAIL read_idx_unexpected got=%h", mon_got);
        end else begin
          mon_exp = exp_rd.pop_front();
          if (mon_got !== mon_exp) begin
            bad++; $display("FAIL read_idx got=%h exp=%h", mon_got, mon_exp);
          end
        end
        if (buf_auto && !bus.is_shrink) buf_q.push_back(dat(bus.read_idx));
      end
      if (buf_auto && bus.read_data_valid && bus.read_data_ready && buf_q.size() != 0)
        void'(buf_q.pop_front());
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        total++;
        if (exp_rsp0.size() == 0) begin
          bad++; $display("FAIL rsp0_unexpected got=%h", bus.rsp0_data);
        end else begin
          mon_d = exp_rsp0.pop_front();
          if (bus.rsp0_data !== mon_d) begin
            bad++; $display("FAIL rsp0_data got=%h exp=%h", bus.rsp0_data, mon_d);
          end
        end
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        total++;
        if (exp_rsp1.size() == 0) begin
          bad++; $display("FAIL rsp1_unexpected got=%h", bus.rsp1_data);
        end else begin
          mon_d = exp_rsp1.pop_front();
          if (bus.rsp1_data !== mon_d) begin
            bad++; $display("FAIL rsp1_data got=%h exp=%h", bus.rsp1_data, mon_d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (buf_auto) begin
      bus.read_data_valid = (buf_q.size() != 0);
      bus.read_data       = (buf_q.size() != 0) ? buf_q[0] : 32'h0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (exp_rd.size() + exp_rsp0.size() + exp_rsp1.size()) != 0; k++) tick();
    total++;
    if ((exp_rd.size() + exp_rsp0.size() + exp_rsp1.size()) != 0) begin
      bad++;
      $display("FAIL drain_timeout left rd=%0d rsp0=%0d rsp1=%0d exp=0",
               exp_rd.size(), exp_rsp0.size(), exp_rsp1.size());
    end
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_is_shrink = 0; bus.req1_is_shrink = 0;
    bus.req0_will_update = 0; bus.req1_will_update = 0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.read_idx_valid, bus.read_idx, bus.read_will_update, bus.is_shrink} !== 11'h0) begin
      bad++; $display("FAIL reset_out got=%b exp=0",
                      {bus.read_idx_valid, bus.read_idx, bus.read_will_update, bus.is_shrink});
    end
    total++;
    if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'h0) begin
      bad++; $display("FAIL reset_hs got=%b exp=0000",
                      {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
    end
    total++;
    if ({bus.read_data_ready, err_o} !== 2'b00) begin
      bad++; $display("FAIL reset_rd_err got=%b exp=00", {bus.read_data_ready, err_o});
    end
`ifdef BUFFET_RDARB_PERF_EN
    total++;
    if ({gnt0_cnt, gnt1_cnt, stall_cnt} !== 48'h0) begin
      bad++; $display("FAIL reset_perf got=%h exp=0", {gnt0_cnt, gnt1_cnt, stall_cnt});
    end
`endif
  endtask

  task automatic test_alternate();
    bus.read_idx_ready = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1; buf_auto = 1;
    bus.req0_idx = 8'h10; bus.req1_idx = 8'h20;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        exp_rd.push_back(mk(8'h10, 0, 0)); exp_rsp0.push_back(dat(8'h10));
      end else begin
        exp_rd.push_back(mk(8'h20, 0, 0)); exp_rsp1.push_back(dat(8'h20));
      end
      @(negedge clk);
      total++;
      if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
        bad++; $display("FAIL alt_grant i=%0d got=%b%b exp=%b%b", i,
                        bus.req0_ready, bus.req1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i == 0) begin
        total++;
        if (bus.read_idx_valid !== 1'b0) begin
          bad++; $display("FAIL alt_latency0 got=%b exp=0", bus.read_idx_valid);
        end
      end
      if (i == 1) begin
        total++;
        if (bus.read_idx_valid !== 1'b1 || bus.read_idx !== 8'h10) begin
          bad++; $display("FAIL alt_latency1 got=%b/%h exp=1/10", bus.read_idx_valid, bus.read_idx);
        end
      end
      tick();
    end
    clear_reqs();
    drain();
    buf_auto = 0; bus.read_data_valid = 0;
  endtask

  task automatic test_tag_full();
    bus.read_idx_ready = 1; bus.read_data_valid = 0;
    bus.req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.req1_idx = 8'h31 + 8'(i);
      exp_rd.push_back(mk(8'h31 + 8'(i), 0, 0));
      exp_rsp1.push_back(dat(8'h31 + 8'(i)));
      @(negedge clk);
      total++;
      if (bus.req1_ready !== 1'b1) begin
        bad++; $display("FAIL full_fill i=%0d got=%b exp=1", i, bus.req1_ready);
      end
      tick();
    end
    bus.req1_idx = 8'h35;
    bus.req0_valid = 1; bus.req0_is_shrink = 1; bus.req0_idx = 8'd3;
    exp_rd.push_back(mk(8'd3, 0, 1));
    @(negedge clk);
    total++;
    if (bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b1) begin
      bad++; $display("FAIL full_block got=r1:%b r0:%b exp=r1:0 r0:1", bus.req1_ready, bus.req0_ready);
    end
    tick();
    bus.req0_valid = 0; bus.req0_is_shrink = 0;
    @(negedge clk);
    total++;
    if (bus.req1_ready !== 1'b0) begin
      bad++; $display("FAIL full_hold got=%b exp=0", bus.req1_ready);
    end
    tick();
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      bus.read_data_valid = 1; bus.read_data = dat(8'h31 + 8'(i));
      @(negedge clk);
      total++;
      if (bus.read_data_ready !== 1'b1 || bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
        bad++; $display("FAIL full_drain i=%0d got=%b%b%b exp=110", i,
                        bus.read_data_ready, bus.rsp1_valid, bus.rsp0_valid);
      end
      tick();
    end
    bus.read_data_valid = 0;
    drain();
  endtask

  task automatic test_interleave();
    int          rq[4] = '{0, 1, 0, 1};
    logic [7:0]  ix[4] = '{8'd1, 8'd2, 8'd6, 8'd5};
    bit          sh[4] = '{0, 0, 1, 0};
    bit          wu[4] = '{0, 1, 0, 1};
    logic [31:0] d[3]  = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0005};
    bus.read_idx_ready = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    exp_rsp0.push_back(d[0]); exp_rsp1.push_back(d[1]); exp_rsp1.push_back(d[2]);
    for (int i = 0; i < 4; i++) begin
      if (rq[i] == 0) begin
        bus.req0_valid = 1; bus.req0_idx = ix[i]; bus.req0_is_shrink = sh[i]; bus.req0_will_update = wu[i];
      end else begin
        bus.req1_valid = 1; bus.req1_idx = ix[i]; bus.req1_is_shrink = sh[i]; bus.req1_will_update = wu[i];
      end
      exp_rd.push_back(mk(ix[i], wu[i], sh[i]));
      @(negedge clk);
      total++;
      if ((rq[i] == 0 ? bus.req0_ready : bus.req1_ready) !== 1'b1) begin
        bad++; $display("FAIL ilv_accept i=%0d got=%b%b exp ready on req%0d", i,
                        bus.req0_ready, bus.req1_ready, rq[i]);
      end
      tick();
      clear_reqs();
    end
    tick(); tick();
    for (int j = 0; j < 3; j++) begin
      bus.read_data_valid = 1; bus.read_data = d[j];
      @(negedge clk);
      total++;
      if (bus.rsp0_valid !== (j == 0) || bus.rsp1_valid !== (j != 0)) begin
        bad++; $display("FAIL ilv_route j=%0d got=%b%b exp=%b%b", j,
                        bus.rsp0_valid, bus.rsp1_valid, (j == 0), (j != 0));
      end
      tick();
    end
    bus.read_data_valid = 0;
    drain();
  endtask

  task automatic test_rsp_stall();
    bus.read_idx_ready = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    bus.req0_valid = 1; bus.req0_idx = 8'd7;
    exp_rd.push_back(mk(8'd7, 0, 0)); exp_rsp0.push_back(32'h5000_0007);
    tick(); clear_reqs();
    bus.req1_valid = 1; bus.req1_idx = 8'd8;
    exp_rd.push_back(mk(8'd8, 0, 0)); exp_rsp1.push_back(32'h5000_0008);
    tick(); clear_reqs();
    tick();
    bus.rsp0_ready = 0;
    bus.read_data_valid = 1; bus.read_data = 32'h5000_0007;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.read_data_ready !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.rsp0_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold i=%0d got=rdy%b v1%b v0%b exp=rdy0 v10 v01", i,
                        bus.read_data_ready, bus.rsp1_valid, bus.rsp0_valid);
      end
      tick();
    end
    bus.rsp0_ready = 1;
    @(negedge clk);
    total++;
    if (bus.read_data_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%b exp=1", bus.read_data_ready);
    end
    tick();
    bus.read_data = 32'h5000_0008;
    @(negedge clk);
    total++;
    if (bus.rsp1_valid !== 1'b1 || bus.read_data_ready !== 1'b1) begin
      bad++; $display("FAIL stall_next got=%b%b exp=11", bus.rsp1_valid, bus.read_data_ready);
    end
    tick();
    bus.read_data_valid = 0;
    drain();
  endtask

  task automatic test_err_reset();
    bus.read_data_valid = 1; bus.read_data = 32'h0000_0BAD;
    @(negedge clk);
    total++;
    if ({bus.read_data_ready, bus.rsp0_valid, bus.rsp1_valid, err_o} !== 4'b0000) begin
      bad++; $display("FAIL err_stray got=%b exp=0000",
                      {bus.read_data_ready, bus.rsp0_valid, bus.rsp1_valid, err_o});
    end
    tick();
    bus.read_data_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (err_o !== 1'b1) begin
        bad++; $display("FAIL err_sticky i=%0d got=%b exp=1", i, err_o);
      end
      tick();
    end
    bus.read_idx_ready = 0; bus.rsp0_ready = 1;
    bus.req0_valid = 1; bus.req0_idx = 8'd9;
    exp_rd.push_back(mk(8'd9, 0, 0));
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_accept got=%b exp=1", bus.req0_ready);
    end
    tick();
    clear_reqs();
    bus.read_data_valid = 1; bus.read_data = 32'h1234_5678;
    #2;
    total++;
    if (bus.read_idx_valid !== 1'b1 || bus.read_data_ready !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=%b%b exp=11", bus.read_idx_valid, bus.read_data_ready);
    end
    nreset_i = 0;
    #1;
    test_reset();
    bus.read_data_valid = 0;
    exp_rd.delete(); exp_rsp0.delete(); exp_rsp1.delete();
    tick(); tick();
    nreset_i = 1;
  endtask

  task automatic test_perf();
    bus.read_idx_ready = 0;
    bus.req0_valid = 1; bus.req0_is_shrink = 1; bus.req0_idx = 8'd1;
    exp_rd.push_back(mk(8'd1, 0, 1));
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++; $display("FAIL perf_first got=%b exp=1", bus.req0_ready);
    end
    tick();
    bus.req0_idx = 8'd2;
    exp_rd.push_back(mk(8'd2, 0, 1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.req0_ready !== 1'b0) begin
        bad++; $display("FAIL perf_stall i=%0d got=%b exp=0", i, bus.req0_ready);
      end
      tick();
    end
    bus.read_idx_ready = 1;
    @(negedge clk);
    total++;
    if (bus.req0_ready !== 1'b1) begin
      bad++; $display("FAIL perf_unstall got=%b exp=1", bus.req0_ready);
    end
    tick();
    bus.req0_idx = 8'd3;
    exp_rd.push_back(mk(8'd3, 0, 1));
    tick();
    clear_reqs();
    bus.req1_valid = 1; bus.req1_is_shrink = 1; bus.req1_idx = 8'd4;
    exp_rd.push_back(mk(8'd4, 0, 1));
    tick();
    bus.req1_idx = 8'd5;
    exp_rd.push_back(mk(8'd5, 0, 1));
    tick();
    clear_reqs();
    drain();
`ifdef BUFFET_RDARB_PERF_EN
    total++;
    if (gnt0_cnt !== 16'd3 || gnt1_cnt !== 16'd2 || stall_cnt !== 16'd4) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d/%0d exp=3/2/4", gnt0_cnt, gnt1_cnt, stall_cnt);
    end
`endif
  endtask

  initial begin
    nreset_i = 0;
    clear_reqs();
    bus.req0_idx = 0; bus.req1_idx = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    bus.read_idx_ready = 0; bus.read_data = 0; bus.read_data_valid = 0;
    #1;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    nreset_i = 1;
    test_alternate();
    test_tag_full();
    test_interleave();
    test_rsp_stall();
    test_err_reset();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/buffet_read_arbiter.md
Name: buffet_read_arbiter

Overview:
- Shares one buffet Read/Shrink port between two consumers (requester 0, requester 1).
- Round-robin arbitration on the request side.
- Per-read requester tag FIFO routes in-order read responses back to the issuing requester.
- Shrinks are forwarded in arbitration order, get no response and are not tagged. Sits between the consumers and the buffet read_idx/read_data channels.

Parameters:
IDX_WIDTH, 8, index / shrink-size width
DATA_WIDTH, 32, read data width
TAG_DEPTH, 4, max outstanding (issued, unanswered) non-shrink reads; power of 2, >=2

Ports:
clk  in  1  clock
nreset_i  in  1  asynchronous active-low reset
req0_idx  in  IDX_WIDTH  requester 0 read index or shrink size
req0_will_update  in  1  requester 0 read-will-update flag
req0_is_shrink  in  1  requester 0 op is shrink
req0_valid  in  1  requester 0 request valid
req0_ready  out  1  requester 0 request accepted
req1_idx / req1_will_update / req1_is_shrink / req1_valid / req1_ready  as requester 0, for requester 1
rsp0_data  out  DATA_WIDTH  response data to requester 0
rsp0_valid  out  1  response valid to requester 0
rsp0_ready  in  1  requester 0 accepts response
rsp1_data / rsp1_valid / rsp1_ready  as rsp0, for requester 1
read_idx  out  IDX_WIDTH  to buffet read_idx
read_will_update  out  1  to buffet
is_shrink  out  1  to buffet
read_idx_valid  out  1  to buffet
read_idx_ready  in  1  from buffet
read_data  in  DATA_WIDTH  from buffet
read_data_valid  in  1  from buffet
read_data_ready  out  1  to buffet
err_o  out  1  sticky protocol error

Behaviour:
- Single clock clk; nreset_i asynchronous, active-low. Reset clears all state at once, including mid-transaction.
- Reset values:
  - read_idx_valid=0, read_idx/read_will_update/is_shrink=0.
  - req*_ready=0, rsp*_valid=0, read_data_ready=0, err_o=0.
  - Tag FIFO empty, prio_q=0.
- Eligibility: elig_k = reqk_valid & (reqk_is_shrink | tag_cnt < TAG_DEPTH).
  - tag_cnt is the registered count; a same-cycle pop does not raise eligibility (conservative).
- Grant:
  - Only one eligible requester: it wins.
  - Both eligible: prio_q wins.
  - After any grant to k: prio_q <= ~k. Without a grant, prio_q holds.
- Output stage: one register (out_valid_q plus payload).
  - load = grant_any & (~out_valid_q | read_idx_ready).
  - reqk_ready = grant_k & load; this is combinational and asserts in the same cycle as valid.
  - On load: payload <= winner fields, out_valid_q <= 1.
  - Else if read_idx_ready: out_valid_q <= 0.
  - read_idx_valid = out_valid_q.
- Request latency: accepted at cycle t, presented on read_idx at t+1. Sustained throughput is 1 request/cycle when read_idx_ready=1.
- Tag FIFO:
  - Push winner ID on load of a non-shrink. Shrinks are never pushed.
  - tag_cnt width $clog2(TAG_DEPTH+1); read/write pointers wrap modulo TAG_DEPTH.
  - Simultaneous push and pop: count unchanged.
- Response routing, with head = tag FIFO head ID:
  - rspk_valid = read_data_valid & (tag_cnt!=0) & (head==k); rspk_data = read_data on both ports.
  - read_data_ready = (tag_cnt!=0) & rsp[head]_ready.
  - Pop on read_data_valid & read_data_ready.
- Backpressure: a stalled responder blocks all responses, since the buffet returns data in order. Requests continue until tag_cnt reaches TAG_DEPTH; shrinks still flow when full.
- Errors: err_o set on read_data_valid while tag_cnt==0. It stays set until reset; the data is dropped and read_data_ready stays 0.
- req*_valid deasserting before ready is permitted; no requester state is held.

Optional Feature:
Macro BUFFET_RDARB_PERF_EN.
- Defined: adds output ports gnt0_cnt and gnt1_cnt, 16 bits each.
  - Saturating count of loads per requester, shrinks included. Reset 0.
  - Adds output stall_cnt, 16 bits: saturating count of cycles with any reqk_valid=1 and no load. Reset 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Both requesters valid continuously, idx0=0x10, idx1=0x20, read_idx_ready=1 -> read_idx alternates 0x10,0x20,0x10,...; first request on read_idx at cycle 1 after first accept; first grant to requester 0.
- Requester 1 issues 4 reads, buffet withholds read_data -> 5th read from requester 1 gets req1_ready=0. A req0 shrink (size 3) issued then is still accepted and appears with is_shrink=1.
- Interleaved reads R0(idx 1), R1(idx 2), shrink from R0, R1(idx 5); buffet returns D_a,D_b,D_c -> rsp0 gets D_a, rsp1 gets D_b then D_c; no response for the shrink.
- rsp0_ready=0 while head tag=0 and read_data_valid=1 -> read_data_ready=0 and rsp1_valid=0 until rsp0_ready rises, then D delivered in that cycle.
- read_data_valid=1 with no outstanding reads -> err_o=1 next cycle and stays 1. Assert nreset_i mid-stream -> all outputs return to reset values immediately.
- With BUFFET_RDARB_PERF_EN: 3 loads to req0, 2 to req1, 4 stalled cycles -> gnt0_cnt=3, gnt1_cnt=2, stall_cnt=4.
